uart_rx_frame_ctrl: RTL and testbench

Byte-level framing controller for the UART receive path. It consumes the receiver's byte strobe (rx_done_tick plus the 8-bit data) and hunts for a sync byte. It then captures a length-prefixed payload and checks an XOR checksum. Only validated payloads are released downstream over a valid/ready stream; malformed, corrupted or stalled frames are discarded and flagged.

---
 rtl/uart_pkg.sv | 30 +++
 rtl/uart_frame_buf.sv | 31 +++
 rtl/uart_rx_frame_ctrl.sv | 194 +++++++++++++++++++
 tb/tb_uart_rx_frame_ctrl.sv | 351 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module   : uart_pkg
// Brief    : Shared state, error-code and sync-byte definitions for the
//            UART receive framing controller.
// Revision : 1.0 - initial release
// ============================================================================
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LEN     = 3'd1,
        PAYLOAD = 3'd2,
        CSUM    = 3'd3,
        DRAIN   = 3'd4
    } state_t;

    localparam logic [1:0] ERR_LEN  = 2'b01;
    localparam logic [1:0] ERR_CSUM = 2'b10;
    localparam logic [1:0] ERR_TO   = 2'b11;

    localparam logic [7:0] SYNC_DEFAULT = 8'hA5;

    // A length byte is usable only when it is 1..max_len.
    function automatic logic len_legal(input logic [7:0] b, input int max_len);
        return (b != 8'h00) && (int'(b) <= max_len);
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_frame_buf.sv
`default_nettype none
// ============================================================================
// Module   : uart_frame_buf
// Brief    : Payload store: one synchronous write port, one combinational
//            read port, no reset on the array.
// Revision : 1.0 - initial release
// ============================================================================
module uart_frame_buf #(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [7:0]        wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [7:0]        rdata
);

    logic [7:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[waddr] <= wdata;
        end
    end

    assign rdata = r_mem[raddr];

endmodule
`default_nettype wire

// File: rtl/uart_rx_frame_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_frame_ctrl
// Brief    : Hunts for SYNC, captures a length-prefixed payload, checks its
//            XOR checksum and releases only validated bytes on a stream.
// Revision : 1.0 - initial release
// ============================================================================
module uart_rx_frame_ctrl
    import uart_pkg::*;
#(
    parameter int         MAX_LEN  = 16,
    parameter logic [7:0] SYNC     = SYNC_DEFAULT,
    parameter int         TO_TICKS = 2048
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       s_tick,
    input  logic       rx_done_tick,
    input  logic [7:0] rx_data,
    output logic       out_valid,
    output logic [7:0] out_data,
    output logic       out_last,
    input  logic       out_ready,
    output logic       frame_ok,
    output logic       frame_err,
    output logic [1:0] err_code,
    output logic       overrun,
    output logic       busy
);

    localparam int c_PTR_W  = $clog2(MAX_LEN + 1);
    localparam int c_ADDR_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int c_TO_W   = $clog2(TO_TICKS);
    localparam logic [c_TO_W-1:0] c_TO_LAST = c_TO_W'(TO_TICKS - 1);

    state_t               r_state,    w_state_nxt;
    logic [c_PTR_W-1:0]   r_len,      w_len_nxt;
    logic [c_PTR_W-1:0]   r_wr_ptr,   w_wr_ptr_nxt;
    logic [c_PTR_W-1:0]   r_rd_ptr,   w_rd_ptr_nxt;
    logic [7:0]           r_csum,     w_csum_nxt;
    logic [c_TO_W-1:0]    r_to_cnt,   w_to_cnt_nxt;
    logic [1:0]           r_err_code, w_err_code_nxt;
    logic                 r_frame_ok, w_frame_ok_nxt;
    logic                 r_frame_err, w_frame_err_nxt;
    logic                 r_overrun,  w_overrun_nxt;

    logic [c_PTR_W-1:0]   w_len_m1;
    logic                 w_timed;
    logic                 w_to_fire;
    logic                 w_buf_we;
    logic [7:0]           w_rdata;

    assign w_len_m1 = r_len - c_PTR_W'(1);
    assign w_timed  = (r_state == LEN) || (r_state == PAYLOAD) || (r_state == CSUM);
    // A byte landing on the terminal tick keeps the frame alive.
    assign w_to_fire = w_timed && s_tick && !rx_done_tick && (r_to_cnt == c_TO_LAST);

    uart_frame_buf #(
        .DEPTH  (MAX_LEN),
        .ADDR_W (c_ADDR_W)
    ) u_buf (
        .clk   (clk),
        .we    (w_buf_we),
        .waddr (r_wr_ptr[c_ADDR_W-1:0]),
        .wdata (rx_data),
        .raddr (r_rd_ptr[c_ADDR_W-1:0]),
        .rdata (w_rdata)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_len       <= '0;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_csum      <= '0;
            r_to_cnt    <= '0;
            r_err_code  <= '0;
            r_frame_ok  <= 1'b0;
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_len       <= w_len_nxt;
            r_wr_ptr    <= w_wr_ptr_nxt;
            r_rd_ptr    <= w_rd_ptr_nxt;
            r_csum      <= w_csum_nxt;
            r_to_cnt    <= w_to_cnt_nxt;
            r_err_code  <= w_err_code_nxt;
            r_frame_ok  <= w_frame_ok_nxt;
            r_frame_err <= w_frame_err_nxt;
            r_overrun   <= w_overrun_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_len_nxt       = r_len;
        w_wr_ptr_nxt    = r_wr_ptr;
        w_rd_ptr_nxt    = r_rd_ptr;
        w_csum_nxt      = r_csum;
        w_to_cnt_nxt    = r_to_cnt;
        w_err_code_nxt  = r_err_code;
        w_frame_ok_nxt  = 1'b0;
        w_frame_err_nxt = 1'b0;
        w_overrun_nxt   = 1'b0;
        w_buf_we        = 1'b0;

        if (rx_done_tick) begin
            w_to_cnt_nxt = '0;
        end else if (s_tick && w_timed) begin
            w_to_cnt_nxt = r_to_cnt + c_TO_W'(1);
        end

        unique case (r_state)
            IDLE: begin
                if (rx_done_tick && (rx_data == SYNC)) begin
                    w_state_nxt  = LEN;
                    w_to_cnt_nxt = '0;
                end
            end
            LEN: begin
                if (rx_done_tick) begin
                    if (!len_legal(rx_data, MAX_LEN)) begin
                        w_frame_err_nxt = 1'b1;
                        w_err_code_nxt  = ERR_LEN;
                        w_state_nxt     = IDLE;
                    end else begin
                        w_len_nxt    = c_PTR_W'(rx_data);
                        w_wr_ptr_nxt = '0;
                        w_csum_nxt   = rx_data;
                        w_state_nxt  = PAYLOAD;
                    end
                end
            end
            PAYLOAD: begin
                if (rx_done_tick) begin
                    w_buf_we     = 1'b1;
                    w_wr_ptr_nxt = r_wr_ptr + c_PTR_W'(1);
                    w_csum_nxt   = r_csum ^ rx_data;
                    if (r_wr_ptr == w_len_m1) begin
                        w_state_nxt = CSUM;
                    end
                end
            end
            CSUM: begin
                if (rx_done_tick) begin
                    if (rx_data == r_csum) begin
                        w_frame_ok_nxt = 1'b1;
                        w_rd_ptr_nxt   = '0;
                        w_state_nxt    = DRAIN;
                    end else begin
                        w_frame_err_nxt = 1'b1;
                        w_err_code_nxt  = ERR_CSUM;
                        w_state_nxt     = IDLE;
                    end
                end
            end
            DRAIN: begin
                if (out_ready) begin
                    w_rd_ptr_nxt = r_rd_ptr + c_PTR_W'(1);
                    if (r_rd_ptr == w_len_m1) begin
                        w_state_nxt = IDLE;
                    end
                end
                // Bytes during drain are dropped, never hunted as SYNC.
                if (rx_done_tick) begin
                    w_overrun_nxt = 1'b1;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase

        if (w_to_fire) begin
            w_frame_err_nxt = 1'b1;
            w_err_code_nxt  = ERR_TO;
            w_state_nxt     = IDLE;
            w_to_cnt_nxt    = '0;
        end
    end

    assign out_valid = (r_state == DRAIN);
    assign out_last  = out_valid && (r_rd_ptr == w_len_m1);
    assign out_data  = out_valid ? w_rdata : 8'h00;
    assign frame_ok  = r_frame_ok;
    assign frame_err = r_frame_err;
    assign err_code  = r_err_code;
    assign overrun   = r_overrun;
    assign busy      = (r_state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_frame_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_rx_frame_ctrl
// Brief    : Directed and randomized bench for uart_rx_frame_ctrl with a
//            frame-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_rx_frame_ctrl;

    localparam int         MAX_LEN  = 16;
    localparam logic [7:0] SYNC_B   = 8'hA5;
    localparam int         TO_TICKS = 2048;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx_done_tick = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       out_valid, out_last, frame_ok, frame_err, overrun, busy;
    logic [7:0] out_data;
    logic [1:0] err_code;
    logic       s_tick, out_ready;

    logic tick_dir = 1'b0, tick_rand = 1'b0, ready_dir = 1'b1, ready_rand = 1'b0, rand_en = 1'b0;
    assign s_tick    = tick_dir | (rand_en & tick_rand);
    assign out_ready = rand_en ? ready_rand : ready_dir;

    always #5 clk = ~clk;

    uart_rx_frame_ctrl #(.MAX_LEN(MAX_LEN), .SYNC(SYNC_B), .TO_TICKS(TO_TICKS)) dut (
        .clk(clk), .rst(rst), .s_tick(s_tick), .rx_done_tick(rx_done_tick), .rx_data(rx_data),
        .out_valid(out_valid), .out_data(out_data), .out_last(out_last), .out_ready(out_ready),
        .frame_ok(frame_ok), .frame_err(frame_err), .err_code(err_code), .overrun(overrun), .busy(busy)
    );

    always begin
        @(posedge clk);
        #1;
        tick_rand  = ($urandom_range(0, 7) == 0);
        ready_rand = 1'($urandom_range(0, 1));
    end

    // Monitor: collects transfers and event pulses.
    logic [8:0] obs_q[$];
    int ok_cnt = 0, err_cnt = 0, ovr_cnt = 0, both_cnt = 0, stall_viol = 0;
    logic [1:0] last_err = 2'b00;
    logic       prev_stall = 1'b0;
    logic [8:0] prev_out = '0;

    always @(posedge clk) begin
        if (rst) begin
            prev_stall <= 1'b0;
        end else begin
            if (prev_stall && (!out_valid || ({out_last, out_data} != prev_out)))
                stall_viol <= stall_viol + 1;
            prev_stall <= out_valid && !out_ready;
            prev_out   <= {out_last, out_data};
            if (out_valid && out_ready) obs_q.push_back({out_last, out_data});
            if (frame_ok) ok_cnt <= ok_cnt + 1;
            if (frame_err) begin
                err_cnt  <= err_cnt + 1;
                last_err <= err_code;
            end
            if (overrun) ovr_cnt <= ovr_cnt + 1;
            if (frame_ok && frame_err) both_cnt <= both_cnt + 1;
        end
    end

    int total = 0, passed = 0, failed = 0;
    int obs_rd = 0;
    int exp_kind;
    logic [7:0] exp_pay[$];
    logic [7:0] none[$];
    logic [7:0] f[$];
    logic [7:0] e[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input logic [7:0] b, input int gap);
        cyc(gap);
        rx_data      = b;
        rx_done_tick = 1'b1;
        cyc(1);
        rx_done_tick = 1'b0;
        rx_data      = 8'($urandom);
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (busy && n < 300) begin
            cyc(1);
            n++;
        end
        chk({tag, "_idle"}, busy, 0);
    endtask

    task automatic check_obs(input string tag, input logic [7:0] q[$]);
        chk({tag, "_count"}, obs_q.size() - obs_rd, q.size());
        for (int i = 0; i < q.size(); i++) begin
            if (obs_rd < obs_q.size()) begin
                chk($sformatf("%s_byte%0d", tag, i), obs_q[obs_rd], {(i == q.size() - 1), q[i]});
                obs_rd++;
            end
        end
        obs_rd = obs_q.size();
    endtask

    // Frame-level reference: skip to first SYNC, judge LEN then checksum.
    task automatic model(input logic [7:0] q[$]);
        int i = 0;
        int len;
        logic [7:0] x;
        exp_pay.delete();
        while (i < q.size() && q[i] != SYNC_B) i++;
        len = int'(q[i+1]);
        if (len == 0 || len > MAX_LEN) begin
            exp_kind = 1;
        end else begin
            x = q[i+1];
            for (int k = 0; k < len; k++) begin
                exp_pay.push_back(q[i+2+k]);
                x = x ^ q[i+2+k];
            end
            exp_kind = (q[i+2+len] == x) ? 0 : 2;
        end
    endtask

    task automatic run_frame(input string tag, input logic [7:0] q[$]);
        int ok0 = ok_cnt;
        int err0 = err_cnt;
        model(q);
        foreach (q[k]) send(q[k], $urandom_range(1, 3));
        wait_idle(tag);
        cyc(2);
        if (exp_kind == 0) begin
            chk({tag, "_ok"}, ok_cnt - ok0, 1);
            chk({tag, "_noerr"}, err_cnt - err0, 0);
            check_obs(tag, exp_pay);
        end else begin
            chk({tag, "_err"}, err_cnt - err0, 1);
            chk({tag, "_code"}, last_err, exp_kind);
            chk({tag, "_nook"}, ok_cnt - ok0, 0);
            check_obs(tag, none);
        end
    endtask

    function automatic logic [7:0] xsum(input logic [7:0] q[$]);
        logic [7:0] x = 8'h00;
        foreach (q[k]) x = x ^ q[k];
        return x;
    endfunction

    logic [7:0] bp_data[5];
    logic       bp_last[5];
    logic       bp_rdy[5];

    initial begin
        #50000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int err0, ovr0, ok0;
        bp_rdy  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        bp_data = '{8'h11, 8'h22, 8'h22, 8'h22, 8'h33};
        bp_last = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

        // Reset state
        cyc(3);
        chk("rst_busy", busy, 0);
        chk("rst_valid", out_valid, 0);
        chk("rst_data", out_data, 0);
        chk("rst_last", out_last, 0);
        chk("rst_ok", frame_ok, 0);
        chk("rst_err", frame_err, 0);
        chk("rst_code", err_code, 0);
        chk("rst_ovr", overrun, 0);
        rst = 1'b0;
        cyc(2);

        // Good frame, exact timing
        send(8'hA5, 1); send(8'h03, 1); send(8'h11, 1); send(8'h22, 1); send(8'h33, 1); send(8'h03, 1);
        chk("good_frame_ok", frame_ok, 1);
        chk("good_v0", out_valid, 1);
        chk("good_d0", out_data, 8'h11);
        chk("good_l0", out_last, 0);
        cyc(1);
        chk("good_ok_pulse", frame_ok, 0);
        chk("good_d1", out_data, 8'h22);
        chk("good_l1", out_last, 0);
        cyc(1);
        chk("good_d2", out_data, 8'h33);
        chk("good_l2", out_last, 1);
        cyc(1);
        chk("good_busy", busy, 0);
        chk("good_v3", out_valid, 0);
        chk("good_d3", out_data, 0);
        e = '{8'h11, 8'h22, 8'h33};
        check_obs("good", e);

        // Backpressure
        ovr0 = ovr_cnt;
        send(8'hA5, 1); send(8'h03, 1); send(8'h11, 1); send(8'h22, 1); send(8'h33, 1); send(8'h03, 1);
        for (int i = 0; i < 5; i++) begin
            ready_dir = bp_rdy[i];
            #1;
            chk($sformatf("bp_v%0d", i), out_valid, 1);
            chk($sformatf("bp_d%0d", i), out_data, bp_data[i]);
            chk($sformatf("bp_l%0d", i), out_last, bp_last[i]);
            cyc(1);
        end
        ready_dir = 1'b1;
        chk("bp_busy", busy, 0);
        cyc(1);
        check_obs("bp", e);
        chk("bp_stall", stall_viol, 0);
        chk("bp_ovr", ovr_cnt - ovr0, 0);

        // Bad checksum and bad lengths
        f = '{8'hA5, 8'h02, 8'hAA, 8'hBB, 8'h00};
        run_frame("badcsum", f);
        f = '{8'hA5, 8'h00};
        run_frame("len0", f);
        f = '{8'hA5, 8'h11};
        run_frame("len17", f);

        // Timeout on the 2048th tick
        err0 = err_cnt;
        send(8'hA5, 1); send(8'h04, 1); send(8'h01, 1);
        tick_dir = 1'b1;
        cyc(TO_TICKS - 1);
        chk("to_pre_err", frame_err, 0);
        chk("to_pre_busy", busy, 1);
        cyc(1);
        tick_dir = 1'b0;
        chk("to_err", frame_err, 1);
        chk("to_code", err_code, 2'b11);
        chk("to_busy", busy, 0);
        cyc(2);
        chk("to_cnt", err_cnt - err0, 1);

        // Byte on terminal tick wins
        err0 = err_cnt;
        send(8'hA5, 1); send(8'h04, 1); send(8'h01, 1);
        tick_dir = 1'b1;
        cyc(TO_TICKS - 1);
        send(8'h02, 0);
        tick_dir = 1'b0;
        chk("tie_noerr", frame_err, 0);
        chk("tie_busy", busy, 1);
        e = '{8'h04, 8'h01, 8'h02, 8'h03, 8'h04};
        send(8'h03, 1); send(8'h04, 1); send(xsum(e), 1);
        wait_idle("tie");
        cyc(2);
        chk("tie_errcnt", err_cnt - err0, 0);
        e = '{8'h01, 8'h02, 8'h03, 8'h04};
        check_obs("tie", e);

        // Leading garbage
        f = '{8'h00, 8'hFF, 8'h5A, 8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h03};
        run_frame("garbage", f);

        // Overrun during drain
        ovr0 = ovr_cnt;
        ready_dir = 1'b0;
        send(8'hA5, 1); send(8'h02, 1); send(8'hC3, 1); send(8'h3C, 1); send(8'hFD, 1);
        cyc(2);
        send(SYNC_B, 0);
        chk("ovr_pulse", overrun, 1);
        chk("ovr_hold", out_data, 8'hC3);
        cyc(1);
        chk("ovr_cnt", ovr_cnt - ovr0, 1);
        ready_dir = 1'b1;
        wait_idle("ovr");
        cyc(1);
        e = '{8'hC3, 8'h3C};
        check_obs("ovr", e);
        send(8'h02, 1);
        chk("ovr_not_len", busy, 0);

        // Reset mid-payload
        err0 = err_cnt;
        send(8'hA5, 1); send(8'h04, 1); send(8'h01, 1); send(8'h02, 1);
        rst = 1'b1;
        #2;
        chk("mrst_busy", busy, 0);
        chk("mrst_valid", out_valid, 0);
        chk("mrst_code", err_code, 0);
        chk("mrst_err", frame_err, 0);
        chk("mrst_ok", frame_ok, 0);
        chk("mrst_ovr", overrun, 0);
        cyc(2);
        rst = 1'b0;
        cyc(1);
        chk("mrst_errcnt", err_cnt - err0, 0);
        f = '{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h03};
        run_frame("postrst", f);

        // Randomized frames
        rand_en = 1'b1;
        for (int n = 0; n < 40; n++) begin
            int kind, len, ng;
            logic [7:0] b;
            f.delete();
            kind = $urandom_range(0, 3);
            ng   = $urandom_range(0, 2);
            for (int g = 0; g < ng; g++) begin
                do b = 8'($urandom); while (b == SYNC_B);
                f.push_back(b);
            end
            f.push_back(SYNC_B);
            if (kind == 3) begin
                len = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(MAX_LEN + 1, 255);
                f.push_back(8'(len));
            end else begin
                len = $urandom_range(1, MAX_LEN);
                e.delete();
                e.push_back(8'(len));
                for (int k = 0; k < len; k++) e.push_back(8'($urandom));
                foreach (e[k]) f.push_back(e[k]);
                b = xsum(e);
                if (kind == 2) b = b ^ 8'($urandom_range(1, 255));
                f.push_back(b);
            end
            run_frame($sformatf("rnd%0d", n), f);
        end
        rand_en = 1'b0;
        cyc(2);
        chk("never_both", both_cnt, 0);
        chk("stall_stable", stall_viol, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
`default_nettype wire
